// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// word geometry and the byte-alignment mask.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_SHIFT = $clog2(WORD_BYTES);
  localparam logic [1:0]  ALIGN_MASK = 2'(WORD_BYTES - 1);

endpackage

// File: rtl/dmem_ram.sv
// Word-organised single-port RAM, DEPTH x 32, synchronous write and
// registered read. Contents are never cleared.
module dmem_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Write on enable, read the addressed word every cycle (read-before-write).
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
    r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port: one word request at a
// time over valid/ready, WAIT_CYCLES wait states, then a one-cycle response.
// Optional feature macro: DMEM_STORE_COUNT_EN (adds store_cnt output).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
`ifdef DMEM_STORE_COUNT_EN
  ,
  output logic [15:0]       store_cnt
`endif
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [3:0]  LAST_CNT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t           r_state, w_next;
  logic [3:0]       r_cnt;
  logic             r_we, r_err;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;

  logic             w_accept, w_misalign, w_oor, w_in_resp, w_ram_we;
  logic [IDX_W-1:0] w_req_idx, w_ram_idx;
  logic [31:0]      w_ram_rdata;

  assign w_req_idx  = req_addr[IDX_W+BYTE_SHIFT-1:BYTE_SHIFT];
  assign w_misalign = |(req_addr[1:0] & ALIGN_MASK);
  // Word index >= DEPTH is equivalent to any address bit above the index being set.
  assign w_oor      = |req_addr[ADDR_W-1:IDX_W+BYTE_SHIFT];

  assign req_ready  = (r_state == S_IDLE) && !reset;
  assign w_accept   = req_valid && req_ready;
  assign w_in_resp  = (r_state == S_RESP) && !reset;
  assign w_ram_we   = w_in_resp && r_we && !r_err;

  // The RAM is addressed straight from the request while idle so the
  // registered read is ready by the RESP cycle even with zero wait states.
  assign w_ram_idx  = (r_state == S_IDLE) ? w_req_idx : r_idx;

  assign rsp_valid  = w_in_resp;
  assign rsp_err    = w_in_resp && r_err;
  assign rsp_rdata  = (w_in_resp && !r_we && !r_err) ? w_ram_rdata : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == LAST_CNT) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Wait-state counter, cleared whenever not waiting.
  always_ff @(posedge clk) begin
    if (reset || r_state != S_WAIT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Request latch, loaded only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_idx   <= w_req_idx;
      r_wdata <= req_wdata;
      r_err   <= w_misalign || w_oor;
    end
  end

  dmem_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_idx   (w_ram_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

`ifdef DMEM_STORE_COUNT_EN
  logic [15:0] r_store_cnt;

  // Saturating count of committed, error-free stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_store_cnt <= '0;
    end else if (w_ram_we && r_store_cnt != '1) begin
      r_store_cnt <= r_store_cnt + 16'd1;
    end
  end

  assign store_cnt = r_store_cnt;
`endif

endmodule
